// File: rtl/bf_pkg.sv
// Shared definitions for the Brainfuck CPU UART transmit path.
// Holds the transmitter FSM state encoding and the serial data width.
package bf_pkg;

  localparam int BF_UART_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } bf_uart_state_t;

endpackage

// File: rtl/bf_uart_fifo.sv
// Synchronous single-clock FIFO with first-word fall-through output.
// dout always shows the head entry. full/empty come from the registered count.
// Pushes while full and pops while empty are ignored.
module bf_uart_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == FULL_CNT);
  assign empty  = (r_count == '0);
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign dout   = r_mem[r_rdPtr];

  // Storage array; left unreset so it can map onto plain registers or RAM
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= din;
    end
  end

  // Pointers wrap naturally at DEPTH; the count tracks occupancy
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
        2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/bf_uart_tx.sv
// Buffered UART transmitter for bytes emitted by the Brainfuck CPU.
// A FIFO absorbs CPU output so the core only stalls when the buffer is full.
// Framing is 8N1 by default. Defining BF_UART_TX_PARITY_EN adds an even-parity bit, giving 8E1.
// CLK_FREQ/BAUD must be at least 2 clocks per bit, and FIFO_DEPTH must be a power of two.
module bf_uart_tx
  import bf_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [BF_UART_DATA_W-1:0] wr_data,
  output logic                      full,
  output logic                      busy,
  output logic                      uart_out
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

  bf_uart_state_t            r_state;
  logic [CNT_W-1:0]          r_baudCnt;
  logic [2:0]                r_bitCnt;
  logic [BF_UART_DATA_W-1:0] r_shift;
  logic                      r_uartOut;
  logic                      r_busy;
`ifdef BF_UART_TX_PARITY_EN
  logic                      r_parity;
`endif

  logic [BF_UART_DATA_W-1:0] w_fifoDout;
  logic                      w_fifoFull;
  logic                      w_fifoEmpty;
  logic                      w_pushOk;
  logic                      w_pop;
  logic                      w_baudEnd;

  assign w_pushOk  = wr_en && !w_fifoFull;
  assign w_baudEnd = (r_baudCnt == BAUD_LAST);
  assign w_pop     = !w_fifoEmpty &&
                     ((r_state == IDLE) || ((r_state == STOP) && w_baudEnd));

  assign full     = w_fifoFull;
  assign busy     = r_busy;
  assign uart_out = r_uartOut;

  bf_uart_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BF_UART_DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_en),
    .pop   (w_pop),
    .din   (wr_data),
    .dout  (w_fifoDout),
    .full  (w_fifoFull),
    .empty (w_fifoEmpty)
  );

  // Frame sequencer: the line level and busy flag are registered alongside the state
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_baudCnt <= '0;
      r_bitCnt  <= '0;
      r_shift   <= '0;
      r_uartOut <= 1'b1;
      r_busy    <= 1'b0;
`ifdef BF_UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_baudCnt <= '0;
          r_bitCnt  <= '0;
          if (!w_fifoEmpty) begin
            r_shift   <= w_fifoDout;
`ifdef BF_UART_TX_PARITY_EN
            r_parity  <= ^w_fifoDout;
`endif
            r_state   <= START;
            r_uartOut <= 1'b0;
            r_busy    <= 1'b1;
          end else begin
            r_uartOut <= 1'b1;
            r_busy    <= w_pushOk;
          end
        end

        START: begin
          if (w_baudEnd) begin
            r_baudCnt <= '0;
            r_bitCnt  <= '0;
            r_state   <= DATA;
            r_uartOut <= r_shift[0];
          end else begin
            r_baudCnt <= r_baudCnt + CNT_W'(1);
          end
        end

        DATA: begin
          if (w_baudEnd) begin
            r_baudCnt <= '0;
            r_shift   <= r_shift >> 1;
            r_bitCnt  <= r_bitCnt + 3'd1;
            if (r_bitCnt == 3'd7) begin
`ifdef BF_UART_TX_PARITY_EN
              r_state   <= PARITY;
              r_uartOut <= r_parity;
`else
              r_state   <= STOP;
              r_uartOut <= 1'b1;
`endif
            end else begin
              r_uartOut <= r_shift[1];
            end
          end else begin
            r_baudCnt <= r_baudCnt + CNT_W'(1);
          end
        end

`ifdef BF_UART_TX_PARITY_EN
        PARITY: begin
          if (w_baudEnd) begin
            r_baudCnt <= '0;
            r_state   <= STOP;
            r_uartOut <= 1'b1;
          end else begin
            r_baudCnt <= r_baudCnt + CNT_W'(1);
          end
        end
`endif

        STOP: begin
          if (w_baudEnd) begin
            r_baudCnt <= '0;
            r_bitCnt  <= '0;
            if (!w_fifoEmpty) begin
              r_shift   <= w_fifoDout;
`ifdef BF_UART_TX_PARITY_EN
              r_parity  <= ^w_fifoDout;
`endif
              r_state   <= START;
              r_uartOut <= 1'b0;
            end else begin
              r_state   <= IDLE;
              r_uartOut <= 1'b1;
              r_busy    <= w_pushOk;
            end
          end else begin
            r_baudCnt <= r_baudCnt + CNT_W'(1);
          end
        end

        default: begin
          r_state   <= IDLE;
          r_baudCnt <= '0;
          r_uartOut <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bf_uart_tx.sv
// Self-checking bench for bf_uart_tx with 8 clocks per bit and a 4-entry FIFO.
// A line monitor records every frame as a per-cycle sample vector together with its start cycle.
// Each recorded frame is compared against a frame built from the byte that was written.
// Set BF_UART_TX_PARITY_EN to check 8E1 framing.
`timescale 1ns/1ps
module tb_bf_uart_tx;

  localparam int CPB = 8;
`ifdef BF_UART_TX_PARITY_EN
  localparam int SLOTS = 11;
`else
  localparam int SLOTS = 10;
`endif
  localparam int FRAME_CYC = SLOTS * CPB;

  logic       clk    = 1'b0;
  logic       rst    = 1'b0;
  logic       wrEn   = 1'b0;
  logic [7:0] wrData = 8'h00;
  logic       full;
  logic       busy;
  logic       uartOut;

  int testsRun    = 0;
  int testsFailed = 0;
  int cyc         = 0;

  logic [127:0] frameQ[$];
  int           startQ[$];
  logic         rxBusy  = 1'b0;
  int           rxCyc   = 0;
  int           rxStart = 0;
  logic [127:0] rxSamp  = '0;

  bf_uart_tx #(
    .CLK_FREQ   (8),
    .BAUD       (1),
    .FIFO_DEPTH (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wrEn),
    .wr_data  (wrData),
    .full     (full),
    .busy     (busy),
    .uart_out (uartOut)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Cycle counter used to time stimulus and frame starts
  always @(posedge clk) cyc <= cyc + 1;

  // Line monitor: records the sample vector and start cycle of each frame
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      rxBusy = 1'b0;
    end else begin
      if (!rxBusy && uartOut === 1'b0) begin
        rxBusy  = 1'b1;
        rxCyc   = 0;
        rxSamp  = '0;
        rxStart = cyc;
      end
      if (rxBusy) begin
        rxSamp[rxCyc] = uartOut;
        rxCyc++;
        if (rxCyc == FRAME_CYC) begin
          frameQ.push_back(rxSamp);
          startQ.push_back(rxStart);
          rxBusy = 1'b0;
        end
      end
    end
  end

  // Watchdog so a stuck run still terminates
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference serial frame for one byte: start, 8 data LSB first, optional even parity, stop
  function automatic logic [127:0] expFrame(input logic [7:0] b);
    logic [127:0] f;
    logic         v;
    f = '0;
    for (int s = 0; s < SLOTS; s++) begin
      if (s == 0) v = 1'b0;
      else if (s <= 8) v = b[s-1];
      else if (s == 9 && SLOTS == 11) v = ^b;
      else v = 1'b1;
      for (int c = 0; c < CPB; c++) f[s*CPB+c] = v;
    end
    return f;
  endfunction

  // Count a comparison and report it if it differs
  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one write at the current negedge and advance one cycle (wr_en left high)
  task automatic applyStimulus(input logic [7:0] b, output int atCyc);
    atCyc  = cyc;
    wrEn   = 1'b1;
    wrData = b;
    @(negedge clk);
  endtask

  // Advance to the negedge on which the cycle counter equals target
  task automatic waitUntil(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Compare the recorded frames against the expected byte list, back to back from firstStart
  task automatic checkFrames(input string tag, input logic [7:0] bytes[$], input int firstStart);
    checkOutput({tag, "_count"}, frameQ.size(), bytes.size());
    for (int i = 0; i < bytes.size(); i++) begin
      if (i < frameQ.size()) begin
        checkOutput($sformatf("%s_frame%0d", tag, i), frameQ[i], expFrame(bytes[i]));
        checkOutput($sformatf("%s_start%0d", tag, i), startQ[i], firstStart + i * FRAME_CYC);
      end
    end
  endtask

  initial begin
    int wc;
    int wcTmp;
    int lows;
    logic [7:0] exp[$];

    // Reset held for 4 cycles
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("rst_uart", uartOut, 1'b1);
    checkOutput("rst_full", full, 1'b0);
    checkOutput("rst_busy", busy, 1'b0);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("idle_uart", uartOut, 1'b1);
    checkOutput("idle_busy", busy, 1'b0);
    checkOutput("idle_frames", frameQ.size(), 0);

    // Single byte 0x41, start bit two edges after the write
    frameQ.delete(); startQ.delete();
    applyStimulus(8'h41, wc);
    wrEn = 1'b0;
    checkOutput("single_busy_rise", busy, 1'b1);
    checkOutput("single_uart_n1", uartOut, 1'b1);
    @(negedge clk);
    checkOutput("single_uart_n2", uartOut, 1'b0);
    waitUntil(wc + 1 + FRAME_CYC);
    checkOutput("single_busy_last", busy, 1'b1);
    @(negedge clk);
    checkOutput("single_busy_fall", busy, 1'b0);
    checkOutput("single_uart_idle", uartOut, 1'b1);
    @(negedge clk);
    exp = '{8'h41};
    checkFrames("single", exp, wc + 2);

    // Back-to-back bytes 0x55, 0xAA
    frameQ.delete(); startQ.delete();
    applyStimulus(8'h55, wc);
    applyStimulus(8'hAA, wcTmp);
    wrEn = 1'b0;
    lows = 0;
    for (int i = 0; i < 2 * FRAME_CYC; i++) begin
      if (busy !== 1'b1) lows++;
      @(negedge clk);
    end
    checkOutput("b2b_busy_low", lows, 0);
    checkOutput("b2b_busy_fall", busy, 1'b0);
    @(negedge clk);
    exp = '{8'h55, 8'hAA};
    checkFrames("b2b", exp, wc + 2);

    // Fill and overflow: six writes, the sixth is dropped
    frameQ.delete(); startQ.delete();
    for (int i = 1; i <= 6; i++) begin
      checkOutput($sformatf("fill_full_%0d", i), full, (i == 6));
      applyStimulus(8'(i), wcTmp);
      if (i == 1) wc = wcTmp;
    end
    wrEn = 1'b0;
    checkOutput("fill_full_hold", full, 1'b1);
    waitUntil(wc + 1 + FRAME_CYC);
    checkOutput("fill_full_pre_pop", full, 1'b1);
    @(negedge clk);
    checkOutput("fill_full_post_pop", full, 1'b0);
    waitUntil(wc + 2 + 6 * FRAME_CYC + 5);
    exp = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    checkFrames("fill", exp, wc + 2);

    // Reset during bit 3 of 0x0F with two bytes queued
    frameQ.delete(); startQ.delete();
    applyStimulus(8'h0F, wc);
    applyStimulus(8'h11, wcTmp);
    applyStimulus(8'h22, wcTmp);
    wrEn = 1'b0;
    waitUntil(wc + 2 + 4 * CPB + 3);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_uart", uartOut, 1'b1);
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_full", full, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    frameQ.delete(); startQ.delete();
    lows = 0;
    for (int i = 0; i < 3 * FRAME_CYC; i++) begin
      if (uartOut !== 1'b1) lows++;
      @(negedge clk);
    end
    checkOutput("abort_line_low", lows, 0);
    checkOutput("abort_frames", frameQ.size(), 0);
    checkOutput("abort_busy_after", busy, 1'b0);

    // Write lands on the cycle STOP ends while two bytes are queued
    frameQ.delete(); startQ.delete();
    applyStimulus(8'hA1, wc);
    applyStimulus(8'hB2, wcTmp);
    applyStimulus(8'hC3, wcTmp);
    wrEn = 1'b0;
    waitUntil(wc + 1 + FRAME_CYC);
    checkOutput("pp_full_before", full, 1'b0);
    applyStimulus(8'hD4, wcTmp);
    wrEn = 1'b0;
    checkOutput("pp_full_after", full, 1'b0);
    waitUntil(wc + 2 + 4 * FRAME_CYC);
    checkOutput("pp_busy_end", busy, 1'b0);
    @(negedge clk);
    exp = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    checkFrames("pp", exp, wc + 2);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/bf_uart_tx.md
# bf_uart_tx

Buffered UART transmitter that consumes output bytes produced by the Brainfuck CPU's `.` instruction and serialises them onto `uart_out`. It sits directly downstream of the CPU core's output port and drives the top-level serial pin. A small FIFO decouples CPU execution from the slow serial line, so the core stalls only when the buffer is full.

## Interface
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `BAUD`, default 115_200: serial bit rate. `CLKS_PER_BIT = CLK_FREQ/BAUD`, integer division, must be ≥ 2.
- `FIFO_DEPTH`, default 16: byte buffer depth; power of two, ≥ 2.
- `clk` in 1: system clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-low reset.
- `wr_en` in 1: byte-write strobe from the CPU; one byte per cycle when high.
- `wr_data` in 8: byte to transmit, sampled when `wr_en`=1 and `full`=0.
- `full` out 1: FIFO full; the CPU must stall while this is high.
- `busy` out 1: high while a frame is on the line or the FIFO is non-empty.
- `uart_out` out 1: serial output; idle high, 8N1 framing, LSB first.

## Operation
- Reset (`rst`=0 at an edge): `uart_out`=1, `full`=0, `busy`=0, FIFO emptied, FSM set to IDLE, bit and baud counters cleared. Reset mid-frame aborts the frame. The line returns high on that edge, and the discarded byte is not resent.
- Write acceptance: a write is accepted iff `wr_en`=1 and `full`=0 in the same cycle. A write while `full`=1 is dropped silently with no state change.
- `full` is derived from the registered count, so a pop in the same cycle does not unblock a write that cycle.
- FSM states:
  - IDLE: `uart_out`=1. If the FIFO is non-empty, pop the head byte into the shift register and go to START.
  - START: `uart_out`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: drive `shift[0]` for `CLKS_PER_BIT` cycles, then shift right and increment `bit_cnt`. After the 8th bit, go to PARITY if it is compiled in, otherwise to STOP.
  - PARITY: see Configuration.
  - STOP: `uart_out`=1 for `CLKS_PER_BIT` cycles. At the end, if the FIFO is non-empty, pop and go directly to START with no idle gap; otherwise go to IDLE.
- Baud counter: counts 0..`CLKS_PER_BIT`-1, resets to 0 on each state or bit change, and is held at 0 in IDLE.
- FIFO wrap-around: pointers are `$clog2(FIFO_DEPTH)` bits wide and wrap naturally. The count is `$clog2(FIFO_DEPTH)+1` bits wide.
- Simultaneous push and pop when not full: the count is unchanged and both operations take effect.

## Timing
- Write in cycle N into an empty FIFO with the FSM in IDLE:
  - FIFO becomes non-empty at edge N+1.
  - FSM pops and enters START at edge N+2.
  - `uart_out` goes low from edge N+2.
- Frame length is 10×`CLKS_PER_BIT` cycles, or 11× with parity.
- Back-to-back bytes: the next START begins on the edge that ends STOP.
- `busy` is registered. It rises at edge N+1 after the first accepted write and falls on the edge that enters IDLE with the FIFO empty.
- `full` rises on the edge the count reaches `FIFO_DEPTH` and falls on the edge after a pop.

## Configuration
- `BF_UART_TX_PARITY_EN` defined: the PARITY state is inserted after DATA and drives the even-parity bit (XOR of the 8 data bits) for `CLKS_PER_BIT` cycles. Framing becomes 8E1.
- `BF_UART_TX_PARITY_EN` undefined: the PARITY state and its logic are absent. Framing is 8N1.

## Structure
- Shared package `bf_pkg`: FSM state enum `bf_uart_state_t` (IDLE, START, DATA, PARITY, STOP) and `BF_UART_DATA_W`=8.
- Sub-module `bf_uart_fifo`: synchronous single-clock FIFO parameterised by depth and width. It exposes `push`, `pop`, `din`, `dout`, `full` and `empty`. `dout` shows the head entry, first-word fall-through.
- The top level holds the FSM, baud counter, bit counter and shift register.

## Test plan
Bench settings: `CLK_FREQ`=8, `BAUD`=1, so `CLKS_PER_BIT`=8.
- Reset check: hold `rst`=0 for 4 cycles. Expect `uart_out`=1, `full`=0, `busy`=0; release reset and `uart_out` stays 1 with no writes.
- Single byte 0x41:
  - `uart_out` low from edge N+2 for 8 cycles.
  - Data bits 1,0,0,0,0,0,1,0, 8 cycles each.
  - Stop high for 8 cycles, then idle.
  - With `BF_UART_TX_PARITY_EN`: a parity bit of 0 precedes the stop bit.
- Back-to-back bytes 0x55 then 0xAA written on consecutive cycles: two frames with zero idle cycles between the STOP of the first and the START of the second; `busy` stays high throughout.
- Fill and overflow (`FIFO_DEPTH`=4):
  - Write 6 bytes 0x01..0x06 on consecutive cycles.
  - One is popped at cycle 2, so 0x01..0x05 are accepted and `full`=1 from the cycle after 0x05.
  - 0x06 is dropped; the output sequence is exactly 0x01..0x05.
- Reset mid-frame: assert `rst`=0 during bit 3 of 0x0F with 2 bytes queued. `uart_out`=1 on the next edge and stays high after release; no further frames are sent and the queued bytes are lost.
- Push/pop coincidence: with the FIFO holding 2 bytes, issue a write on the exact cycle STOP ends. The count stays at 2 and the byte order is preserved on the line.
